// File: rtl/dec_pkg.sv
// Shared types and helpers for the registered N-to-2**N one-hot decoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dec_pkg;

    // Upper bounds on the select width and output count any instance may use.
    localparam int unsigned DEC_MAX_SEL_W = 8;
    localparam int unsigned DEC_MAX_OUT   = 256;

    // Default hit-counter width, and an all-ones pattern that is sliced
    // down to the instance counter width to form the saturation value.
    localparam int unsigned DEC_CNT_W_DEF = 8;
    localparam logic [31:0] DEC_CNT_ONES  = '1;

    // Output/skid occupancy of the 2-entry stage.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    // Returns {err, y} at maximum width. y occupies bits [DEC_MAX_OUT-1:0]
    // and err sits in the top bit. Callers slice y down to their NUM_OUT.
    function automatic logic [DEC_MAX_OUT:0] dec_onehot(
        input logic [DEC_MAX_SEL_W-1:0] sel,
        input logic                     en,
        input int unsigned              num_out
    );
        logic [DEC_MAX_OUT:0] r;
        r = '0;
        if (en) begin
            if (32'(sel) < num_out) begin
                r[sel] = 1'b1;
            end else begin
                r[DEC_MAX_OUT] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dec_skid_buf.sv
// Generic 2-entry valid/ready skid stage (output register plus one skid register).
// Latency: 1 cycle from input fire to out_valid when the output register is free.
// Backpressure: in_ready is registered and drops only when both entries are full.
//
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/in_data upstream;
//        out_valid/out_ready/out_data downstream.
module dec_skid_buf
    import dec_pkg::*;
#(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    state_e       state;
    state_e       next_state;
    logic [W-1:0] skid_q;
    logic         in_fire;
    logic         out_fire;

    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        next_state = state;
        case (state)
            EMPTY: begin
                if (in_fire) next_state = ONE;
            end
            ONE: begin
                if (in_fire && !out_fire) begin
                    next_state = TWO;
                end else if (!in_fire && out_fire) begin
                    next_state = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) next_state = ONE;
            end
            default: next_state = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= EMPTY;
            in_ready <= 1'b0;
            out_data <= '0;
            skid_q   <= '0;
        end else begin
            state <= next_state;
            // Registered ready: look ahead so a full stage never accepts.
            in_ready <= (next_state != TWO);
            if (state == TWO) begin
                // in_ready is low here, so only the drain path exists.
                if (out_fire) out_data <= skid_q;
            end else if (in_fire) begin
                // A new beat goes straight to the output register if it is
                // empty or being consumed this cycle; otherwise it parks.
                if (state == EMPTY || out_fire) begin
                    out_data <= in_data;
                end else begin
                    skid_q <= in_data;
                end
            end
        end
    end

endmodule

// File: rtl/dec_nto2n_reg.sv
// Registered SEL_W-to-NUM_OUT one-hot decoder with enable and out-of-range flag.
// Latency: 1 cycle input fire to out_valid; 1 beat/cycle while out_ready=1.
// Backpressure: 2-entry skid stage, registered in_ready, no beat ever dropped.
//
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/in_sel/in_en upstream;
//        out_valid/out_ready/out_y/out_err downstream.
// Optional macro DEC_HIT_COUNT_EN adds per-output saturating hit counters with
// cnt_idx/cnt_val read port and cnt_clr clear.
module dec_nto2n_reg
    import dec_pkg::*;
#(
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned NUM_OUT = 4,
    parameter int unsigned CNT_W   = DEC_CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_OUT-1:0] out_y,
`ifdef DEC_HIT_COUNT_EN
    output logic               out_err,
    input  logic [SEL_W-1:0]   cnt_idx,
    output logic [CNT_W-1:0]   cnt_val,
    input  logic               cnt_clr
`else
    output logic               out_err
`endif
);

    if (SEL_W < 1 || SEL_W > DEC_MAX_SEL_W || NUM_OUT < 2 ||
        NUM_OUT > (2 ** SEL_W) || CNT_W < 1 || CNT_W > 32) begin : g_bad_cfg
        $error("dec_nto2n_reg: illegal SEL_W/NUM_OUT/CNT_W combination");
    end

    localparam logic [CNT_W-1:0] CNT_SAT = DEC_CNT_ONES[CNT_W-1:0];

    logic [DEC_MAX_OUT:0] dec_word;
    logic [NUM_OUT:0]     dec_beat;
    logic [NUM_OUT:0]     out_beat;
    logic                 unused_dec;

    assign dec_word   = dec_onehot(DEC_MAX_SEL_W'(in_sel), in_en, NUM_OUT);
    assign dec_beat   = {dec_word[DEC_MAX_OUT], dec_word[NUM_OUT-1:0]};
    // Bits above NUM_OUT are always zero for a legal configuration.
    assign unused_dec = &{1'b0, dec_word};

    dec_skid_buf #(
        .W (NUM_OUT + 1)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (dec_beat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_beat)
    );

    assign out_err = out_beat[NUM_OUT];
    assign out_y   = out_beat[NUM_OUT-1:0];

`ifdef DEC_HIT_COUNT_EN
    logic [CNT_W-1:0] cnt_q [NUM_OUT];
    logic             out_fire;

    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            // Clear wins over a same-cycle increment.
            for (int i = 0; i < int'(NUM_OUT); i++) cnt_q[i] <= '0;
        end else if (out_fire) begin
            for (int i = 0; i < int'(NUM_OUT); i++) begin
                if (out_y[i] && cnt_q[i] != CNT_SAT) cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end

    // Indices at or beyond NUM_OUT match no entry and read as zero.
    always_comb begin
        cnt_val = '0;
        for (int i = 0; i < int'(NUM_OUT); i++) begin
            if (cnt_idx == SEL_W'(i)) cnt_val = cnt_q[i];
        end
    end
`else
    logic [CNT_W-1:0] unused_cnt_sat;
    assign unused_cnt_sat = CNT_SAT;
`endif

endmodule

// File: tb/tb_dec_nto2n_reg.sv
// Self-checking bench for dec_nto2n_reg: two instances (4 outputs, 3 outputs).
// Inputs are driven 1 time unit after each rising edge; outputs are checked
// at that same point, i.e. they reflect the edge just taken.
module tb_dec_nto2n_reg;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: SEL_W=2, NUM_OUT=4.
    logic       a_in_valid, a_in_ready, a_in_en, a_out_valid, a_out_ready, a_out_err;
    logic [1:0] a_in_sel;
    logic [3:0] a_out_y;
    // Instance B: SEL_W=2, NUM_OUT=3.
    logic       b_in_valid, b_in_ready, b_in_en, b_out_valid, b_out_ready, b_out_err;
    logic [1:0] b_in_sel;
    logic [2:0] b_out_y;
`ifdef DEC_HIT_COUNT_EN
    logic [1:0] a_cnt_idx, b_cnt_idx;
    logic [1:0] a_cnt_val;
    logic [7:0] b_cnt_val;
    logic       a_cnt_clr, b_cnt_clr;
`endif

    dec_nto2n_reg #(.SEL_W(2), .NUM_OUT(4), .CNT_W(2)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_sel    (a_in_sel),
        .in_en     (a_in_en),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_y     (a_out_y),
`ifdef DEC_HIT_COUNT_EN
        .out_err   (a_out_err),
        .cnt_idx   (a_cnt_idx),
        .cnt_val   (a_cnt_val),
        .cnt_clr   (a_cnt_clr)
`else
        .out_err   (a_out_err)
`endif
    );

    dec_nto2n_reg #(.SEL_W(2), .NUM_OUT(3), .CNT_W(8)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_sel    (b_in_sel),
        .in_en     (b_in_en),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_y     (b_out_y),
`ifdef DEC_HIT_COUNT_EN
        .out_err   (b_out_err),
        .cnt_idx   (b_cnt_idx),
        .cnt_val   (b_cnt_val),
        .cnt_clr   (b_cnt_clr)
`else
        .out_err   (b_out_err)
`endif
    );

    typedef struct {
        logic [1:0] sel;
        logic       en;
        logic [3:0] y;
        logic       err;
    } vec_t;

    vec_t va [4];
    vec_t vb [5];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Stimulus tables.
        va[0] = '{sel: 2'd0, en: 1'b1, y: 4'b0001, err: 1'b0};
        va[1] = '{sel: 2'd1, en: 1'b1, y: 4'b0010, err: 1'b0};
        va[2] = '{sel: 2'd2, en: 1'b1, y: 4'b0100, err: 1'b0};
        va[3] = '{sel: 2'd3, en: 1'b1, y: 4'b1000, err: 1'b0};
        vb[0] = '{sel: 2'd1, en: 1'b0, y: 4'b0000, err: 1'b0};
        vb[1] = '{sel: 2'd3, en: 1'b1, y: 4'b0000, err: 1'b1};
        vb[2] = '{sel: 2'd2, en: 1'b1, y: 4'b0100, err: 1'b0};
        vb[3] = '{sel: 2'd0, en: 1'b1, y: 4'b0001, err: 1'b0};
        vb[4] = '{sel: 2'd3, en: 1'b0, y: 4'b0000, err: 1'b0};

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_sel = '0; a_in_en = 1'b0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_sel = '0; b_in_en = 1'b0; b_out_ready = 1'b1;
`ifdef DEC_HIT_COUNT_EN
        a_cnt_idx = 2'd1; a_cnt_clr = 1'b0;
        b_cnt_idx = 2'd3; b_cnt_clr = 1'b0;
`endif

        // Reset held for three edges.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_out_valid", 32'(a_out_valid), 32'd0);
            check("rst_out_y",     32'(a_out_y),     32'd0);
            check("rst_in_ready",  32'(a_in_ready),  32'd0);
        end
        check("rst_out_err", 32'(a_out_err), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rel_in_ready",  32'(a_in_ready),  32'd1);
        check("rel_out_valid", 32'(a_out_valid), 32'd0);

        // First beat: sel=2.
        a_in_valid = 1'b1; a_in_sel = 2'd2; a_in_en = 1'b1;
        tick();
        a_in_valid = 1'b0;
        check("first_valid", 32'(a_out_valid), 32'd1);
        check("first_y",     32'(a_out_y),     32'b0100);
        check("first_err",   32'(a_out_err),   32'd0);
        tick();
        check("first_drain", 32'(a_out_valid), 32'd0);

        // Back-to-back streaming, no bubbles.
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1; a_in_sel = va[i].sel; a_in_en = va[i].en;
            tick();
            check($sformatf("stream%0d_valid", i), 32'(a_out_valid), 32'd1);
            check($sformatf("stream%0d_y", i),     32'(a_out_y),     32'(va[i].y));
            check($sformatf("stream%0d_err", i),   32'(a_out_err),   32'(va[i].err));
            check($sformatf("stream%0d_rdy", i),   32'(a_in_ready),  32'd1);
        end
        a_in_valid = 1'b0;
        tick();
        check("stream_end_valid", 32'(a_out_valid), 32'd0);

        // Enable / range on the 3-output instance.
        for (int i = 0; i < 5; i++) begin
            b_in_valid = 1'b1; b_in_sel = vb[i].sel; b_in_en = vb[i].en;
            tick();
            check($sformatf("range%0d_valid", i), 32'(b_out_valid), 32'd1);
            check($sformatf("range%0d_y", i),     32'(b_out_y),     32'(vb[i].y[2:0]));
            check($sformatf("range%0d_err", i),   32'(b_out_err),   32'(vb[i].err));
        end
        b_in_valid = 1'b0;
        tick();
        check("range_end_valid", 32'(b_out_valid), 32'd0);

        // Back-pressure: fill both entries, a third offered beat is refused.
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_sel = 2'd1; a_in_en = 1'b1;
        tick();
        check("bp1_y",   32'(a_out_y),    32'b0010);
        check("bp1_rdy", 32'(a_in_ready), 32'd1);
        a_in_sel = 2'd3;
        tick();
        check("bp2_y",   32'(a_out_y),    32'b0010);
        check("bp2_rdy", 32'(a_in_ready), 32'd0);
        a_in_sel = 2'd0;   // offered while full: must be ignored
        tick();
        check("bp3_y",     32'(a_out_y),     32'b0010);
        check("bp3_valid", 32'(a_out_valid), 32'd1);
        check("bp3_rdy",   32'(a_in_ready),  32'd0);
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        tick();
        check("bp4_y",     32'(a_out_y),     32'b1000);
        check("bp4_valid", 32'(a_out_valid), 32'd1);
        check("bp4_rdy",   32'(a_in_ready),  32'd1);
        tick();
        check("bp5_valid", 32'(a_out_valid), 32'd0);

        // Mid-stream reset while both entries are full.
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_sel = 2'd0; a_in_en = 1'b1;
        tick();
        a_in_sel = 2'd2;
        tick();
        check("mid_full_rdy", 32'(a_in_ready), 32'd0);
        a_in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", 32'(a_out_valid), 32'd0);
        check("mid_rst_y",     32'(a_out_y),     32'd0);
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        tick();
        check("mid_rel_rdy",   32'(a_in_ready),  32'd1);
        check("mid_rel_valid", 32'(a_out_valid), 32'd0);
        tick();
        check("mid_no_ghost",  32'(a_out_valid), 32'd0);

`ifdef DEC_HIT_COUNT_EN
        // Counters were cleared by the reset above.
        check("cnt_after_rst", 32'(a_cnt_val), 32'd0);
        for (int i = 0; i < 5; i++) begin
            a_in_valid = 1'b1; a_in_sel = 2'd1; a_in_en = 1'b1;
            tick();
        end
        a_in_valid = 1'b0;
        tick();
        check("cnt_sat", 32'(a_cnt_val), 32'd3);
        a_cnt_idx = 2'd0;
        #1;
        check("cnt_idx0", 32'(a_cnt_val), 32'd0);
        check("cnt_oor_b", 32'(b_cnt_val), 32'd0);
        a_cnt_idx = 2'd1;
        // Clear coincides with a delivered sel=1 beat.
        a_in_valid = 1'b1; a_in_sel = 2'd1;
        tick();
        a_in_valid = 1'b0;
        a_cnt_clr = 1'b1;
        tick();
        a_cnt_clr = 1'b0;
        check("cnt_clr", 32'(a_cnt_val), 32'd0);
        a_in_valid = 1'b1;
        tick();
        tick();
        a_in_valid = 1'b0;
        tick();
        check("cnt_two", 32'(a_cnt_val), 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
